prim_byte_compactor: RTL and testbench
======================================

Name: prim_byte_compactor

Overview:
- Upstream feeder for the packer FIFO.
- Accepts DataW-bit words with a sparse byte mask and removes the disabled bytes.
- Emits fully packed DataW-bit words in arrival byte order; lowest enabled byte goes first.
- A flush request drains a final partial word with a contiguous low-aligned mask, so the downstream packer only ever sees dense data.

Parameters:
- DataW, 32, data width in bits; must be a multiple of 8 and at least 16.
- NumBytes, DataW/8, derived: bytes per word.
- CntW, $clog2(2*NumBytes+1), derived: width of the byte count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- clr_i  in  1  synchronous clear of all buffered state
- valid_i  in  1  input word valid
- data_i  in  DataW  input data
- mask_i  in  NumBytes  byte enables; any pattern allowed, including 0
- ready_o  out  1  input accepted when valid_i && ready_o
- flush_i  in  1  request to drain residual bytes
- flush_done_o  out  1  one-cycle pulse when a flush completes
- valid_o  out  1  output word valid
- data_o  out  DataW  packed output data; bytes above the valid count are zero
- mask_o  out  NumBytes  contiguous low mask of valid output bytes
- ready_i  in  1  output accepted when valid_o && ready_i

Behaviour:
- State:
  - byte buffer buf_q of 2*NumBytes bytes; byte 0 is the oldest.
  - cnt_q (CntW bits), number of valid bytes.
  - flush_q
  - flush_done_q
  - Invariant: buffer bytes at index >= cnt_q are zero.
- Reset (rst_ni low at a clock edge) and clr_i both zero every register. Resulting outputs: ready_o=1, valid_o=0, data_o=0, mask_o=0, flush_done_o=0.
- Output decode from registers only; no combinational path from valid_i to valid_o.
  - valid_o = (cnt_q >= NumBytes) || (flush_q && cnt_q != 0)
  - data_o = buf_q bytes [NumBytes-1:0]
  - mask_o = all ones if cnt_q >= NumBytes, else low cnt_q bits set
  - ready_o = !flush_q && (cnt_q <= NumBytes)
- Push: push_n = popcount(mask_i). The enabled bytes are compacted in ascending index order.
- Pop: pop_n = popcount(mask_o) when valid_o && ready_i, else 0.
- Next state: shift the buffer down by pop_n bytes, zero-filling the top. Then write the compacted input at byte offset cnt_q - pop_n. cnt_d = cnt_q - pop_n + push_n, never exceeding 2*NumBytes.
- Latency: a byte accepted in cycle t can appear on data_o in cycle t+1.
- Simultaneous push and pop in the same cycle are fully supported with no bubble. Sustained full-mask traffic runs at 1 word/cycle.
- mask_i = 0 with valid_i: the handshake completes and the buffer is unchanged.
- Flush sequence:
  - flush_i sets flush_q when flush_q is clear; flush_i is ignored while flush_q is set.
  - While flush_q is set, ready_o=0.
  - flush_q clears on the cycle where cnt_d = 0; flush_done_q is set the same cycle, so flush_done_o pulses for one cycle on the following cycle.
  - If cnt_q = 0 when flush_i rises, flush_done_o pulses the next cycle.
- clr_i has priority over push, pop and flush. A clr_i during a flush suppresses flush_done_o.
- Stability: while valid_o && !ready_i && !clr_i, valid_o, data_o and mask_o must hold next cycle. The RTL asserts this.

Decomposition:
- No shared package is needed; CntW and NumBytes are local derived parameters.
- One combinational sub-module, prim_byte_compact_comb (params DataW). It takes data/mask and returns the compacted data plus the popcount.
- The top level holds the buffer, counter and flush control.

Test Plan (DataW=32):
- Dense pass-through: push 0x44332211 with mask 0xF while ready_i=1 -> next cycle valid_o=1, data_o=0x44332211, mask_o=0xF; the following cycle valid_o=0.
- Sparse merge: push 0xDDCCBBAA with mask 0xA, then 0x44332211 with mask 0x5 -> data_o=0x3311DDBB, mask_o=0xF, cnt returns to 0.
- Flush partial: push 0x00332211 with mask 0x7, then pulse flush_i -> data_o=0x00332211, mask_o=0x7, ready_o=0 until popped; flush_done_o pulses exactly 1 cycle after the pop.
- Backpressure: ready_i=0, push mask 0xF twice -> cnt=8, ready_o=0, the third push stalls, data_o stable. Raise ready_i -> two words out on consecutive cycles, ready_o=1 after the first pop.
- Clear during flush: cnt=3, flush active, assert clr_i together with valid_i -> next cycle cnt=0, valid_o=0, ready_o=1, flush_done_o never pulses.
- Reset mid-stream: rst_ni low for 1 cycle with cnt=6 -> all outputs at their reset values; the next push behaves as from an empty buffer.

Source files
------------

// File: rtl/prim_byte_compact_comb.sv
// Purpose: gathers the enabled bytes of one word into the low byte lanes, keeping ascending index order.
// Latency: purely combinational, so it adds no cycles.
// Backpressure: none; it has no handshake and the caller decides when to use the result.
// Ports: data_i/mask_i are the sparse input word, data_o is the compacted word with zero-filled
//        upper lanes, and cnt_o is the number of enabled bytes (the popcount of mask_i).
module prim_byte_compact_comb #(
    parameter int DataW = 32,
    localparam int NumBytes = DataW / 8,
    localparam int CntW = $clog2(2 * NumBytes + 1)
) (
    input  logic [DataW-1:0]    data_i,
    input  logic [NumBytes-1:0] mask_i,
    output logic [DataW-1:0]    data_o,
    output logic [CntW-1:0]     cnt_o
);

    logic [DataW-1:0] comp;
    logic [CntW-1:0]  idx;

    // idx is the next free output lane; each enabled byte takes that lane and advances it.
    always_comb begin
        comp = '0;
        idx  = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if (mask_i[i]) begin
                comp[8*idx +: 8] = data_i[8*i +: 8];
                idx = idx + CntW'(1);
            end
        end
    end

    assign data_o = comp;
    assign cnt_o  = idx;

endmodule

// File: rtl/prim_byte_compactor.sv
// Purpose: removes disabled bytes from sparse input words and emits dense, low-aligned words; a flush drains the remainder.
// Latency: a byte accepted in cycle t can appear on data_o in cycle t+1.
// Backpressure: ready_o drops when more than one word is buffered or a flush is in progress; outputs hold while ready_i is low.
// Ports: clk_i/rst_ni (sync, active-low), clr_i (sync clear); the input handshake is valid_i/ready_o with data_i/mask_i;
//        flush_i requests a drain and flush_done_o pulses when it ends; the output handshake is valid_o/ready_i with data_o/mask_o.
module prim_byte_compactor #(
    parameter int DataW = 32,
    localparam int NumBytes = DataW / 8,
    localparam int CntW = $clog2(2 * NumBytes + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                valid_i,
    input  logic [DataW-1:0]    data_i,
    input  logic [NumBytes-1:0] mask_i,
    output logic                ready_o,
    input  logic                flush_i,
    output logic                flush_done_o,
    output logic                valid_o,
    output logic [DataW-1:0]    data_o,
    output logic [NumBytes-1:0] mask_o,
    input  logic                ready_i
);

    localparam logic [CntW-1:0] NumBytesC = CntW'(NumBytes);

    logic [2*DataW-1:0] buf_q, buf_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic               flush_done_q, flush_done_d;

    logic [DataW-1:0]   comp_dat;
    logic [CntW-1:0]    comp_cnt;
    logic               full;
    logic               push_fire;
    logic [CntW-1:0]    push_n;
    logic [CntW-1:0]    pop_n;
    logic [CntW-1:0]    wr_off;
    logic               flush_act;

    prim_byte_compact_comb #(.DataW(DataW)) u_comb (
        .data_i (data_i),
        .mask_i (mask_i),
        .data_o (comp_dat),
        .cnt_o  (comp_cnt)
    );

    // All outputs are decoded from registers only, so valid_i never reaches valid_o in the same cycle.
    assign full         = (cnt_q >= NumBytesC);
    assign valid_o      = full || (flush_q && (cnt_q != '0));
    assign ready_o      = !flush_q && (cnt_q <= NumBytesC);
    assign data_o       = buf_q[DataW-1:0];
    assign flush_done_o = flush_done_q;

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < NumBytes; i++) begin
            mask_o[i] = (cnt_q > CntW'(i));
        end
    end

    assign push_fire = valid_i && ready_o;
    assign push_n    = push_fire ? comp_cnt : '0;
    assign pop_n     = (valid_o && ready_i) ? (full ? NumBytesC : cnt_q) : '0;
    assign wr_off    = cnt_q - pop_n;

    always_comb begin
        // Shift out the popped bytes first, then append the new bytes at the residual count.
        // ready_o guarantees wr_off <= NumBytes, so the append always fits in the buffer.
        // Buffer bytes above the count are always zero, which makes the OR-merge safe.
        buf_d = buf_q >> (8 * pop_n);
        if (push_fire) begin
            buf_d = buf_d | ({{DataW{1'b0}}, comp_dat} << (8 * wr_off));
        end
        cnt_d = wr_off + push_n;

        // A new flush_i while a flush is running is absorbed by the OR.
        // An empty buffer completes the flush in the same cycle it starts.
        flush_act    = flush_q || flush_i;
        flush_d      = flush_act;
        flush_done_d = 1'b0;
        if (flush_act && (cnt_d == '0)) begin
            flush_d      = 1'b0;
            flush_done_d = 1'b1;
        end

        if (clr_i) begin
            buf_d        = '0;
            cnt_d        = '0;
            flush_d      = 1'b0;
            flush_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            flush_done_q <= flush_done_d;
        end
    end

    // A stalled output word must not change until it is taken or cleared.
    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !clr_i) |=> (valid_o && $stable(data_o) && $stable(mask_o)));

endmodule

// File: tb/tb_prim_byte_compactor.sv
module tb_prim_byte_compactor;

    localparam int NB = 4;

    logic        clk;
    logic        rst_n;
    logic        clr_i;
    logic        valid_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic        ready_o;
    logic        flush_i;
    logic        flush_done_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  mask_o;
    logic        ready_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    prim_byte_compactor #(.DataW(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .ready_i      (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue, oldest first, plus the flush state.
    logic [7:0] mq[$];
    bit         mflush;
    bit         mdone;

    always @(posedge clk) begin : model
        int  n;
        bit  vld;
        bit  rdy;
        bit  act;
        if (!rst_n || clr_i) begin
            mq.delete();
            mflush = 0;
            mdone  = 0;
        end else begin
            n   = mq.size();
            vld = (n >= NB) || (mflush && n != 0);
            rdy = !mflush && (n <= NB);
            if (vld && ready_i) begin
                for (int k = 0; k < ((n < NB) ? n : NB); k++) void'(mq.pop_front());
            end
            if (valid_i && rdy) begin
                for (int i = 0; i < NB; i++) if (mask_i[i]) mq.push_back(data_i[8*i +: 8]);
            end
            act   = mflush || flush_i;
            mdone = 0;
            if (act && mq.size() == 0) begin
                mflush = 0;
                mdone  = 1;
            end else begin
                mflush = act;
            end
        end
    end

    always @(negedge clk) begin : compare
        int          n;
        logic [31:0] ed;
        logic [3:0]  em;
        if (cmp_en) begin
            n  = mq.size();
            ed = '0;
            em = '0;
            for (int i = 0; i < NB; i++) begin
                if (i < n) begin
                    ed[8*i +: 8] = mq[i];
                    em[i]        = 1'b1;
                end
            end
            check("m_valid_o", 32'(valid_o), 32'((n >= NB) || (mflush && n != 0)));
            check("m_ready_o", 32'(ready_o), 32'(!mflush && (n <= NB)));
            check("m_data_o", data_o, ed);
            check("m_mask_o", 32'(mask_o), 32'(em));
            check("m_flush_done_o", 32'(flush_done_o), 32'(mdone));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] m);
        valid_i = 1'b1;
        data_i  = d;
        mask_i  = m;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 0; clr_i = 0; valid_i = 0; data_i = '0; mask_i = '0;
        flush_i = 0; ready_i = 0;
        cyc();
        cmp_en = 1;
        cyc();
        rst_n = 1;
        check("reset_ready_o", 32'(ready_o), 32'd1);
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_mask_o", 32'(mask_o), 32'd0);

        // Dense pass-through
        ready_i = 1;
        push(32'h44332211, 4'hF);
        cyc();
        valid_i = 0;
        check("dense_valid", 32'(valid_o), 32'd1);
        check("dense_data", data_o, 32'h44332211);
        check("dense_mask", 32'(mask_o), 32'hF);
        cyc();
        check("dense_valid_after", 32'(valid_o), 32'd0);

        // Sparse merge
        push(32'hDDCCBBAA, 4'hA);
        cyc();
        push(32'h44332211, 4'h5);
        cyc();
        valid_i = 0;
        check("sparse_data", data_o, 32'h3311DDBB);
        check("sparse_mask", 32'(mask_o), 32'hF);
        cyc();
        check("sparse_empty", 32'(valid_o), 32'd0);

        // Flush partial
        push(32'h00332211, 4'h7);
        cyc();
        valid_i = 0;
        flush_i = 1;
        cyc();
        flush_i = 0;
        check("flush_valid", 32'(valid_o), 32'd1);
        check("flush_data", data_o, 32'h00332211);
        check("flush_mask", 32'(mask_o), 32'h7);
        check("flush_ready", 32'(ready_o), 32'd0);
        cyc();
        check("flush_done_pulse", 32'(flush_done_o), 32'd1);
        cyc();
        check("flush_done_once", 32'(flush_done_o), 32'd0);

        // Backpressure
        ready_i = 0;
        push(32'h04030201, 4'hF);
        cyc();
        push(32'h08070605, 4'hF);
        cyc();
        check("bp_ready_full", 32'(ready_o), 32'd0);
        check("bp_data", data_o, 32'h04030201);
        push(32'h0C0B0A09, 4'hF);
        cyc();
        check("bp_data_stable", data_o, 32'h04030201);
        ready_i = 1;
        cyc();
        check("bp_word1", data_o, 32'h08070605);
        check("bp_ready_after_pop", 32'(ready_o), 32'd1);
        cyc();
        valid_i = 0;
        check("bp_word2", data_o, 32'h0C0B0A09);
        cyc();
        check("bp_drained", 32'(valid_o), 32'd0);

        // Clear during flush
        ready_i = 0;
        push(32'h00C0B0A0, 4'h7);
        cyc();
        valid_i = 0;
        flush_i = 1;
        cyc();
        flush_i = 0;
        check("clr_pre_valid", 32'(valid_o), 32'd1);
        clr_i = 1;
        push(32'h99999999, 4'hF);
        cyc();
        clr_i = 0;
        valid_i = 0;
        check("clr_valid", 32'(valid_o), 32'd0);
        check("clr_ready", 32'(ready_o), 32'd1);
        check("clr_done", 32'(flush_done_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("clr_no_done", 32'(flush_done_o), 32'd0);
        end

        // Empty-mask push is accepted and leaves the buffer unchanged
        push(32'h12345678, 4'h0);
        cyc();
        valid_i = 0;
        check("zero_mask_valid", 32'(valid_o), 32'd0);
        check("zero_mask_ready", 32'(ready_o), 32'd1);

        // Reset mid-stream
        push(32'h11111111, 4'hF);
        cyc();
        push(32'h00002222, 4'h3);
        cyc();
        valid_i = 0;
        check("rst_pre_valid", 32'(valid_o), 32'd1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_data", data_o, 32'd0);
        ready_i = 1;
        push(32'h55667788, 4'hF);
        cyc();
        valid_i = 0;
        check("rst_next_push", data_o, 32'h55667788);
        cyc();

        // Mixed deterministic traffic checked only by the model
        for (int i = 0; i < 80; i++) begin
            valid_i = (i % 4 != 3);
            mask_i  = 4'((i * 7) % 16);
            data_i  = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
            ready_i = (i % 3 != 0);
            flush_i = (i % 19 == 5);
            cyc();
        end
        valid_i = 0;
        ready_i = 1;
        flush_i = 1;
        cyc();
        flush_i = 0;
        for (int i = 0; i < 6; i++) cyc();

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
